// File: rtl/radiant_event_hdr_reader.sv
// Pops one event from the event-type FIFO, reads its header dwords over a
// wishbone master port and forwards each dword as one AXI-stream beat.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   enable_i               allows a new event to start
//   event_ready_i          event pending (FWFT valid of the event-type FIFO)
//   event_ready_type_i     type of the pending event
//   event_readout_ready_o  one-cycle pop of the event-type FIFO
//   wbm_*                  wishbone master read port (byte addressed, 9 bit)
//   hdr_t*                 header stream out; tuser carries the event type
//   busy_o                 high whenever the reader is not idle
//   status_o               sticky {timeout, bus error, identifier mismatch}
//   status_clr_i           clears status_o (a same-cycle set takes priority)
//   event_count_o          events fully forwarded, wraps at 16 bits
module radiant_event_hdr_reader #(
  parameter int unsigned NUM_DWORDS = 8,
  parameter logic [8:0]  BASE_ADDR  = 9'h100,
  parameter logic [31:0] IDENTIFIER = 32'h52444530,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        event_ready_i,
  input  logic        event_ready_type_i,
  output logic        event_readout_ready_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [8:0]  wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic [31:0] hdr_tdata_o,
  output logic        hdr_tvalid_o,
  input  logic        hdr_tready_i,
  output logic        hdr_tlast_o,
  output logic        hdr_tuser_o,
  output logic        busy_o,
  output logic [2:0]  status_o,
  input  logic        status_clr_i,
  output logic [15:0] event_count_o
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_DWORDS - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_READ,
    S_WAIT,
    S_PUSH
  } state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  tmo_cnt;

  logic        in_wait;
  logic        got_err;
  logic        got_ack;
  logic        got_tmo;
  logic        id_bad;
  logic        last_beat;
  logic [3:0]  idx_nxt;
  logic [8:0]  adr_nxt;

  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;

  // err outranks ack; the timeout only fires on a cycle with neither
  assign in_wait   = (state == S_WAIT);
  assign got_err   = in_wait && wbm_err_i;
  assign got_ack   = in_wait && !wbm_err_i && wbm_ack_i;
  assign got_tmo   = in_wait && !wbm_err_i && !wbm_ack_i
                     && (tmo_cnt == TMO_LAST);
  assign id_bad    = got_ack && (idx == 4'd0)
                     && (wbm_dat_i != IDENTIFIER);
  assign last_beat = (idx == LAST_IDX);
  assign idx_nxt   = idx + 4'd1;
  assign adr_nxt   = BASE_ADDR + {3'b000, idx_nxt, 2'b00};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state                 <= S_IDLE;
      idx                   <= '0;
      tmo_cnt               <= '0;
      event_readout_ready_o <= 1'b0;
      wbm_cyc_o             <= 1'b0;
      wbm_stb_o             <= 1'b0;
      wbm_adr_o             <= BASE_ADDR;
      hdr_tdata_o           <= '0;
      hdr_tvalid_o          <= 1'b0;
      hdr_tlast_o           <= 1'b0;
      hdr_tuser_o           <= 1'b0;
      busy_o                <= 1'b0;
      status_o              <= '0;
      event_count_o         <= '0;
    end else begin
      event_readout_ready_o <= 1'b0;
      status_o <= (status_clr_i ? 3'b000 : status_o)
                  | {got_tmo, got_err, id_bad};

      unique case (state)
        S_IDLE: begin
          if (event_ready_i && enable_i) begin
            state                 <= S_POP;
            event_readout_ready_o <= 1'b1;
            busy_o                <= 1'b1;
          end
        end

        // FIFO is FWFT: the type is still valid during the pop cycle
        S_POP: begin
          hdr_tuser_o <= event_ready_type_i;
          idx         <= '0;
          wbm_cyc_o   <= 1'b1;
          wbm_stb_o   <= 1'b1;
          wbm_adr_o   <= BASE_ADDR;
          state       <= S_READ;
        end

        S_READ: begin
          wbm_stb_o <= 1'b0;
          tmo_cnt   <= '0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          if (got_err || got_tmo) begin
            hdr_tdata_o <= 32'hFFFF_FFFF;
          end else if (got_ack) begin
            hdr_tdata_o <= wbm_dat_i;
          end
          if (got_err || got_tmo || got_ack) begin
            wbm_cyc_o    <= 1'b0;
            hdr_tvalid_o <= 1'b1;
            hdr_tlast_o  <= last_beat;
            state        <= S_PUSH;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        S_PUSH: begin
          if (hdr_tready_i) begin
            hdr_tvalid_o <= 1'b0;
            hdr_tlast_o  <= 1'b0;
            if (last_beat) begin
              busy_o        <= 1'b0;
              event_count_o <= event_count_o + 16'd1;
              state         <= S_IDLE;
            end else begin
              idx       <= idx_nxt;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_adr_o <= adr_nxt;
              state     <= S_READ;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radiant_event_hdr_reader.sv
// Directed bench for radiant_event_hdr_reader: wishbone slave model,
// event FIFO model and stream monitor around a linear stimulus sequence.
module tb_radiant_event_hdr_reader;

  localparam logic [8:0]  BASE = 9'h100;
  localparam logic [31:0] ID   = 32'h52444530;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        event_ready_i;
  logic        event_ready_type_i = 1'b0;
  logic        event_readout_ready_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [8:0]  wbm_adr_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic [31:0] hdr_tdata_o;
  logic        hdr_tvalid_o;
  logic        hdr_tready_i = 1'b0;
  logic        hdr_tlast_o;
  logic        hdr_tuser_o;
  logic        busy_o;
  logic [2:0]  status_o;
  logic        status_clr_i = 1'b0;
  logic [15:0] event_count_o;

  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int popped = 0;
  int stb_cnt = 0;
  int wait4 = 0;
  int noack_idx = -1;
  int err_idx = -1;

  logic [31:0] mem [16];
  logic [31:0] bdat [$];
  logic        blast [$];
  logic        buser [$];
  logic [8:0]  sadr [$];
  logic [8:0]  off;
  int          k;

  always #5 clk_i = ~clk_i;

  radiant_event_hdr_reader dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .enable_i              (enable_i),
    .event_ready_i         (event_ready_i),
    .event_ready_type_i    (event_ready_type_i),
    .event_readout_ready_o (event_readout_ready_o),
    .wbm_cyc_o             (wbm_cyc_o),
    .wbm_stb_o             (wbm_stb_o),
    .wbm_we_o              (wbm_we_o),
    .wbm_sel_o             (wbm_sel_o),
    .wbm_adr_o             (wbm_adr_o),
    .wbm_dat_i             (wbm_dat_i),
    .wbm_ack_i             (wbm_ack_i),
    .wbm_err_i             (wbm_err_i),
    .hdr_tdata_o           (hdr_tdata_o),
    .hdr_tvalid_o          (hdr_tvalid_o),
    .hdr_tready_i          (hdr_tready_i),
    .hdr_tlast_o           (hdr_tlast_o),
    .hdr_tuser_o           (hdr_tuser_o),
    .busy_o                (busy_o),
    .status_o              (status_o),
    .status_clr_i          (status_clr_i),
    .event_count_o         (event_count_o)
  );

  // event-type FIFO model
  assign event_ready_i = (pushed != popped);
  always @(posedge clk_i)
    if (event_readout_ready_o && pushed != popped)
      popped <= popped + 1;

  // wishbone slave: acks in the cycle after stb
  always @(negedge clk_i) begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    if (wbm_stb_o) begin
      stb_cnt++;
      sadr.push_back(wbm_adr_o);
    end
    if (wbm_cyc_o && !wbm_stb_o) begin
      off = wbm_adr_o - BASE;
      k = int'(off[5:2]);
      if (k == 4) wait4++;
      if (k == err_idx) begin
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        wbm_dat_i = 32'h0BAD_0BAD;
      end else if (k != noack_idx) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = mem[k];
      end
    end
  end

  // stream monitor
  always @(negedge clk_i) begin
    if (hdr_tvalid_o && hdr_tready_i) begin
      bdat.push_back(hdr_tdata_o);
      blast.push_back(hdr_tlast_o);
      buser.push_back(hdr_tuser_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_log();
    bdat.delete();
    blast.delete();
    buser.delete();
    sadr.delete();
  endtask

  task automatic wait_count(input logic [15:0] tgt, input string tag);
    int n = 0;
    while (event_count_o !== tgt && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic check_beats(input string tag, input int n, input int bad);
    chk({tag, "_nbeats"}, 32'(bdat.size()), 32'(n));
    for (int i = 0; i < n && i < bdat.size(); i++) begin
      logic [31:0] e;
      e = ((i % 8) == bad) ? 32'hFFFF_FFFF : mem[i % 8];
      chk($sformatf("%s_d%0d", tag, i), bdat[i], e);
      chk($sformatf("%s_l%0d", tag, i), 32'(blast[i]),
          32'((i % 8) == 7));
      chk($sformatf("%s_u%0d", tag, i), 32'(buser[i]), 32'd1);
    end
  endtask

  initial begin
    int n;
    int p0;
    int s0;

    mem[0] = ID;
    for (int i = 1; i < 16; i++) mem[i] = 32'(i);

    // reset values
    step();
    step();
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_we", 32'(wbm_we_o), 32'd0);
    chk("rst_sel", 32'(wbm_sel_o), 32'hF);
    chk("rst_adr", 32'(wbm_adr_o), 32'h100);
    chk("rst_pop", 32'(event_readout_ready_o), 32'd0);
    chk("rst_tvalid", 32'(hdr_tvalid_o), 32'd0);
    chk("rst_tlast", 32'(hdr_tlast_o), 32'd0);
    chk("rst_tdata", hdr_tdata_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_status", 32'(status_o), 32'd0);
    chk("rst_count", 32'(event_count_o), 32'd0);
    rst_i = 1'b0;
    step();

    // basic event
    enable_i = 1'b1;
    hdr_tready_i = 1'b1;
    event_ready_type_i = 1'b1;
    pushed++;
    step();
    chk("ev1_busy", 32'(busy_o), 32'd1);
    wait_count(16'd1, "ev1");
    step();
    check_beats("ev1", 8, -1);
    chk("ev1_pops", 32'(popped), 32'd1);
    chk("ev1_status", 32'(status_o), 32'd0);
    chk("ev1_stbs", 32'(stb_cnt), 32'd8);
    chk("ev1_idle", 32'(busy_o), 32'd0);

    // tready stall on beat 3
    clear_log();
    pushed++;
    n = 0;
    while (bdat.size() < 2 && n < 200) begin
      step();
      n++;
    end
    chk("stall_reach", 32'(n < 200), 32'd1);
    hdr_tready_i = 1'b0;
    n = 0;
    while (!hdr_tvalid_o && n < 50) begin
      step();
      n++;
    end
    chk("stall_tvalid", 32'(hdr_tvalid_o), 32'd1);
    s0 = stb_cnt;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_data", hdr_tdata_o, mem[2]);
      chk("stall_last", 32'(hdr_tlast_o), 32'd0);
      chk("stall_valid", 32'(hdr_tvalid_o), 32'd1);
      chk("stall_stb", 32'(wbm_stb_o), 32'd0);
    end
    chk("stall_nostb", 32'(stb_cnt - s0), 32'd0);
    hdr_tready_i = 1'b1;
    wait_count(16'd2, "ev2");
    step();
    check_beats("ev2", 8, -1);

    // identifier mismatch
    clear_log();
    mem[0] = 32'h1234_5678;
    pushed++;
    wait_count(16'd3, "idm");
    step();
    check_beats("idm", 8, -1);
    chk("idm_status", 32'(status_o), 32'd1);
    status_clr_i = 1'b1;
    step();
    status_clr_i = 1'b0;
    chk("idm_clr", 32'(status_o), 32'd0);
    mem[0] = ID;

    // no ack on dword 4
    clear_log();
    noack_idx = 4;
    wait4 = 0;
    pushed++;
    wait_count(16'd4, "tmo");
    step();
    check_beats("tmo", 8, 4);
    chk("tmo_status", 32'(status_o), 32'd4);
    chk("tmo_wait", 32'(wait4), 32'd255);
    noack_idx = -1;
    status_clr_i = 1'b1;
    step();
    status_clr_i = 1'b0;

    // bus error on dword 6 while clear is held: set wins
    clear_log();
    err_idx = 6;
    status_clr_i = 1'b1;
    pushed++;
    n = 0;
    while (!(hdr_tvalid_o && bdat.size() == 6) && n < 200) begin
      step();
      n++;
    end
    chk("err_reach", 32'(n < 200), 32'd1);
    chk("err_setwins", 32'(status_o), 32'd2);
    status_clr_i = 1'b0;
    wait_count(16'd5, "err");
    step();
    check_beats("err", 8, 6);
    chk("err_status", 32'(status_o), 32'd2);
    err_idx = -1;

    // reset during wait of dword 2
    clear_log();
    pushed++;
    n = 0;
    while (!(wbm_cyc_o && !wbm_stb_o && wbm_adr_o == 9'h108)
           && n < 100) begin
      step();
      n++;
    end
    chk("rmid_reach", 32'(n < 100), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rmid_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rmid_stb", 32'(wbm_stb_o), 32'd0);
    chk("rmid_tvalid", 32'(hdr_tvalid_o), 32'd0);
    chk("rmid_busy", 32'(busy_o), 32'd0);
    chk("rmid_count", 32'(event_count_o), 32'd0);
    chk("rmid_status", 32'(status_o), 32'd0);
    step();
    rst_i = 1'b0;
    step();
    clear_log();
    pushed++;
    wait_count(16'd1, "rnew");
    step();
    chk("rnew_adr0", 32'(sadr[0]), 32'h100);
    chk("rnew_adr7", 32'(sadr[7]), 32'h11C);
    check_beats("rnew", 8, -1);

    // enable dropped during event 2 of 3
    clear_log();
    p0 = popped;
    pushed += 3;
    n = 0;
    while (popped != p0 + 2 && n < 200) begin
      step();
      n++;
    end
    chk("en_reach", 32'(n < 200), 32'd1);
    enable_i = 1'b0;
    wait_count(16'd3, "en");
    repeat (20) step();
    check_beats("en", 16, -1);
    chk("en_pops", 32'(popped - p0), 32'd2);
    chk("en_count", 32'(event_count_o), 32'd3);
    chk("en_busy", 32'(busy_o), 32'd0);
    chk("en_pending", 32'(event_ready_i), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
